// File: rtl/xosera_bus_ctrl.sv
// Xosera 8-bit register bus sequencer: queues 8/16-bit register requests and plays
// each byte out as SETUP, a CS_WIDTH chip-select strobe and a GAP, returning reads.
module xosera_bus_ctrl #(
   parameter int unsigned CS_WIDTH = 2,
   parameter int unsigned GAP      = 2,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic        req_word_i,
   input  logic        req_bytesel_i,
   input  logic [3:0]  req_reg_num_i,
   input  logic [15:0] req_data_i,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_data_o,
   output logic        busy_o,
   output logic        bus_cs_n_o,
   output logic        bus_rd_nwr_o,
   output logic [3:0]  bus_reg_num_o,
   output logic        bus_bytesel_o,
   output logic [7:0]  bus_data_o,
   input  logic [7:0]  bus_data_i,
   output logic [1:0]  dbg_state_o
);

   // Request handshake: a request transfers on a clk edge where req_valid_i && req_ready_o.
   // req_ready_o depends only on FIFO fill (never on req_valid_i or a same-cycle pop).
   // The response side has no ready: rsp_valid_o is a one-cycle pulse.

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned MAXC = (CS_WIDTH > GAP) ? CS_WIDTH : GAP;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   typedef struct packed {
      logic        write;
      logic        word;
      logic        bytesel;
      logic [3:0]  reg_num;
      logic [15:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr, rd_next, count;
   entry_t          req_entry, head, ld_entry;
   logic            push, pop, empty, full, last_byte, more, load, ld_odd, ld_bytesel;
   logic [7:0]      ld_data, rd_hi;
   state_t          state;
   logic [CW-1:0]   cnt;
   logic            odd;

   always_comb begin
      req_entry         = '0;
      req_entry.write   = req_write_i;
      req_entry.word    = req_word_i;
      req_entry.bytesel = req_bytesel_i;
      req_entry.reg_num = req_reg_num_i;
      req_entry.data    = req_data_i;
   end

   assign rd_next     = rd_ptr + 1'b1;
   assign count       = wr_ptr - rd_ptr;
   assign empty       = (count == '0);
   assign full        = (count == FULL_CNT);
   assign push        = req_valid_i && !full;
   assign req_ready_o = !full;
   assign busy_o      = (state != ST_IDLE) || !empty;
   assign dbg_state_o = state;

   // The head entry stays queued for its whole access, so it is the one on the bus.
   assign head      = mem[rd_ptr[AW-1:0]];
   assign last_byte = !head.word || odd;
   assign more      = (count[AW:1] != '0) || push;
   assign pop       = (state == ST_GAP) && (cnt == '0) && last_byte;
   assign load      = ((state == ST_IDLE) && (!empty || push)) ||
                      ((state == ST_GAP) && (cnt == '0) && (!last_byte || more));
   assign ld_odd    = (state == ST_GAP) && !last_byte;

   // Next entry to put on the bus; an empty FIFO bypasses the incoming request.
   always_comb begin
      ld_entry = head;
      if (state == ST_IDLE) begin
         if (empty) ld_entry = req_entry;
      end else if (!ld_odd) begin
         ld_entry = (count[AW:1] != '0) ? mem[rd_next[AW-1:0]] : req_entry;
      end
   end

   assign ld_bytesel = ld_entry.word ? ld_odd : ld_entry.bytesel;
   assign ld_data    = (ld_entry.word && !ld_odd) ? ld_entry.data[15:8] : ld_entry.data[7:0];

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= req_entry;
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         odd           <= 1'b0;
         rd_hi         <= 8'h00;
         bus_cs_n_o    <= 1'b1;
         bus_rd_nwr_o  <= 1'b1;
         bus_reg_num_o <= 4'h0;
         bus_bytesel_o <= 1'b0;
         bus_data_o    <= 8'h00;
         rsp_valid_o   <= 1'b0;
         rsp_data_o    <= 16'h0000;
      end else begin
         rsp_valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) state <= ST_SETUP;
            end
            ST_SETUP: begin
               state      <= ST_STROBE;
               bus_cs_n_o <= 1'b0;
               cnt        <= CW'(CS_WIDTH - 1);
            end
            ST_STROBE: begin
               if (cnt == '0) begin
                  state      <= ST_GAP;
                  bus_cs_n_o <= 1'b1;
                  cnt        <= CW'(GAP - 1);
                  if (!head.write) begin
                     if (last_byte) begin
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= head.word ? {rd_hi, bus_data_i} : {8'h00, bus_data_i};
                     end else begin
                        rd_hi <= bus_data_i;
                     end
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else if (load) state <= ST_SETUP;
               else           state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         if (load) begin
            odd           <= ld_odd;
            bus_rd_nwr_o  <= !ld_entry.write;
            bus_reg_num_o <= ld_entry.reg_num;
            bus_bytesel_o <= ld_bytesel;
            bus_data_o    <= ld_data;
         end
      end
   end

endmodule

// File: tb/tb_xosera_bus_ctrl.sv
// Bench for xosera_bus_ctrl: transaction-level model (byte index/phase arithmetic),
// per-cycle compare process, response scoreboard and hand-computed directed checks.
module tb_xosera_bus_ctrl;

   localparam int CS    = 2;
   localparam int GP    = 2;
   localparam int DEPTH = 4;
   localparam int P     = 1 + CS + GP;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        req_valid_i, req_ready_o, req_write_i, req_word_i, req_bytesel_i;
   logic [3:0]  req_reg_num_i;
   logic [15:0] req_data_i;
   logic        rsp_valid_o;
   logic [15:0] rsp_data_o;
   logic        busy_o, bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o;
   logic [3:0]  bus_reg_num_o;
   logic [7:0]  bus_data_o, bus_data_i;
   logic [1:0]  dbg_state_o;

   xosera_bus_ctrl #(.CS_WIDTH(CS), .GAP(GP), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
      .req_word_i(req_word_i), .req_bytesel_i(req_bytesel_i), .req_reg_num_i(req_reg_num_i),
      .req_data_i(req_data_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .busy_o(busy_o), .bus_cs_n_o(bus_cs_n_o), .bus_rd_nwr_o(bus_rd_nwr_o),
      .bus_reg_num_o(bus_reg_num_o), .bus_bytesel_o(bus_bytesel_o), .bus_data_o(bus_data_o),
      .bus_data_i(bus_data_i), .dbg_state_o(dbg_state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct packed {
      logic        write;
      logic        word;
      logic        bytesel;
      logic [3:0]  reg_num;
      logic [15:0] data;
   } req_t;

   req_t        mq[$];
   logic [15:0] exp_q[$];
   bit          m_active, m_pushed, chk_en, rand_bus;
   int          m_k, cyc, checks, failures;
   logic [7:0]  m_rd0, m_data;
   logic [15:0] m_rsp_data;
   logic        m_cs_n, m_rd_nwr, m_bytesel, m_rsp_valid;
   logic [3:0]  m_reg;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_active = 0; m_k = 0; m_rd0 = 8'h00; m_rsp_data = 16'h0000;
      m_cs_n = 1'b1; m_rd_nwr = 1'b1; m_reg = 4'h0; m_bytesel = 1'b0;
      m_data = 8'h00; m_rsp_valid = 1'b0;
   endtask

   // Advance the model across one rising edge, using the inputs as they stood before it.
   task automatic model_edge();
      req_t h;
      int   nb, b, j;
      bit   do_push;
      m_pushed = 0;
      nb = 1;
      if (reset_i !== 1'b1) begin
         model_reset();
         return;
      end
      if (m_active) begin
         h  = mq[0];
         nb = h.word ? 2 : 1;
         b  = m_k / P;
         j  = m_k % P;
         if (!h.write && j == CS) begin
            if (b == nb - 1) begin
               m_rsp_data = h.word ? {m_rd0, bus_data_i} : {8'h00, bus_data_i};
               exp_q.push_back(m_rsp_data);
            end else begin
               m_rd0 = bus_data_i;
            end
         end
      end
      do_push = req_valid_i && (mq.size() < DEPTH);
      if (m_active) begin
         m_k++;
         if (m_k == nb * P) begin
            void'(mq.pop_front());
            m_active = 0;
         end
      end
      if (do_push) begin
         mq.push_back(req_t'{req_write_i, req_word_i, req_bytesel_i, req_reg_num_i, req_data_i});
         m_pushed = 1;
      end
      if (!m_active && mq.size() != 0) begin
         m_active = 1;
         m_k = 0;
      end
      m_rsp_valid = 1'b0;
      if (m_active) begin
         h  = mq[0];
         nb = h.word ? 2 : 1;
         b  = m_k / P;
         j  = m_k % P;
         m_cs_n      = !(j >= 1 && j <= CS);
         m_rd_nwr    = !h.write;
         m_reg       = h.reg_num;
         m_bytesel   = h.word ? (b == 1) : h.bytesel;
         m_data      = (h.word && b == 0) ? h.data[15:8] : h.data[7:0];
         m_rsp_valid = !h.write && (b == nb - 1) && (j == CS + 1);
      end else begin
         m_cs_n = 1'b1;
      end
   endtask

   // compare process
   always @(negedge clk) begin
      if (chk_en) begin
         int avail;
         check("ready",   32'(req_ready_o),   32'(mq.size() < DEPTH));
         check("busy",    32'(busy_o),        32'(mq.size() != 0));
         check("cs_n",    32'(bus_cs_n_o),    32'(m_cs_n));
         check("rd_nwr",  32'(bus_rd_nwr_o),  32'(m_rd_nwr));
         check("reg_num", 32'(bus_reg_num_o), 32'(m_reg));
         check("bytesel", 32'(bus_bytesel_o), 32'(m_bytesel));
         check("wdata",   32'(bus_data_o),    32'(m_data));
         check("rsp_valid", 32'(rsp_valid_o), 32'(m_rsp_valid));
         check("rsp_data",  32'(rsp_data_o),  32'(m_rsp_data));
         if (rsp_valid_o === 1'b1) begin
            avail = exp_q.size();
            check("rsp_expected", 32'(avail != 0), 32'd1);
            if (avail != 0) check("rsp_scoreboard", 32'(rsp_data_o), 32'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      if (rand_bus) bus_data_i = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
      @(negedge clk);
   endtask

   task automatic push_req(input logic w, input logic wd, input logic bs,
                           input logic [3:0] rn, input logic [15:0] d, output int edge_idx);
      bit done;
      done = 0;
      edge_idx = -1;
      req_valid_i = 1'b1; req_write_i = w; req_word_i = wd;
      req_bytesel_i = bs; req_reg_num_i = rn; req_data_i = d;
      for (int n = 0; n < 100 && !done; n++) begin
         tick();
         if (m_pushed) begin
            done = 1;
            edge_idx = cyc - 1;
         end
      end
      req_valid_i = 1'b0;
      check("push_accept", 32'(done), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((mq.size() != 0 || m_active) && n < 500) begin
         tick();
         n++;
      end
      check("drain_bound", 32'(mq.size() == 0 && !m_active), 32'd1);
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, base, lows, r;
      int acc[5];
      checks = 0; failures = 0; cyc = 0; chk_en = 0; rand_bus = 1;
      req_valid_i = 0; req_write_i = 0; req_word_i = 0; req_bytesel_i = 0;
      req_reg_num_i = 0; req_data_i = 0; bus_data_i = 0; reset_i = 1'b1;
      #2 reset_i = 1'b0;
      model_reset();
      chk_en = 1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_cs_n",   32'(bus_cs_n_o),    32'd1);
      check("rst_rd_nwr", 32'(bus_rd_nwr_o),  32'd1);
      check("rst_ready",  32'(req_ready_o),   32'd1);
      check("rst_busy",   32'(busy_o),        32'd0);
      check("rst_rsp",    32'(rsp_data_o),    32'd0);
      check("rst_reg",    32'(bus_reg_num_o), 32'd0);
      check("rst_state_idle", 32'(dbg_state_o), 32'd0);
      reset_i = 1'b1;
      repeat (2) tick();

      // byte write reg 3, bytesel 1, 0x005A
      push_req(1'b1, 1'b0, 1'b1, 4'd3, 16'h005A, e);
      base = e;
      wait_to(base + 1); check("bw_setup_cs", 32'(bus_cs_n_o), 32'd1);
      wait_to(base + 2);
      check("bw_cs2",   32'(bus_cs_n_o),    32'd0);
      check("bw_data",  32'(bus_data_o),    32'h5A);
      check("bw_rdnwr", 32'(bus_rd_nwr_o),  32'd0);
      check("bw_bsel",  32'(bus_bytesel_o), 32'd1);
      check("bw_reg",   32'(bus_reg_num_o), 32'd3);
      wait_to(base + 3); check("bw_cs3", 32'(bus_cs_n_o), 32'd0);
      wait_to(base + 4); check("bw_cs4", 32'(bus_cs_n_o), 32'd1);
      wait_to(base + 5); check("bw_busy5", 32'(busy_o), 32'd1);
      wait_to(base + 6); check("bw_busy6", 32'(busy_o), 32'd0);
      wait_idle();

      // word write reg 5, 0x1234
      push_req(1'b1, 1'b1, 1'b0, 4'd5, 16'h1234, e);
      base = e;
      wait_to(base + 2);
      check("ww_cs2",   32'(bus_cs_n_o),    32'd0);
      check("ww_bsel0", 32'(bus_bytesel_o), 32'd0);
      check("ww_hi",    32'(bus_data_o),    32'h12);
      wait_to(base + 6); check("ww_cs6", 32'(bus_cs_n_o), 32'd1);
      wait_to(base + 7);
      check("ww_cs7",   32'(bus_cs_n_o),    32'd0);
      check("ww_bsel1", 32'(bus_bytesel_o), 32'd1);
      check("ww_lo",    32'(bus_data_o),    32'h34);
      wait_to(base + 8);  check("ww_cs8", 32'(bus_cs_n_o), 32'd0);
      wait_to(base + 10); check("ww_busy10", 32'(busy_o), 32'd1);
      wait_to(base + 11); check("ww_busy11", 32'(busy_o), 32'd0);
      wait_idle();

      // word read reg 2: 0xAB then 0xCD on the bus
      rand_bus = 0;
      bus_data_i = 8'hAB;
      push_req(1'b0, 1'b1, 1'b0, 4'd2, 16'h0000, e);
      base = e;
      wait_to(base + 2);
      check("wr_rdnwr", 32'(bus_rd_nwr_o),  32'd1);
      check("wr_reg",   32'(bus_reg_num_o), 32'd2);
      wait_to(base + 4); bus_data_i = 8'hCD;
      wait_to(base + 8); check("wr_rsp8", 32'(rsp_valid_o), 32'd0);
      wait_to(base + 9);
      check("wr_rsp9",  32'(rsp_valid_o), 32'd1);
      check("wr_data9", 32'(rsp_data_o),  32'hABCD);
      wait_to(base + 10);
      check("wr_rsp10",  32'(rsp_valid_o), 32'd0);
      check("wr_hold10", 32'(rsp_data_o),  32'hABCD);
      wait_idle();

      // byte read, bytesel 0, bus 0x7E
      bus_data_i = 8'h7E;
      push_req(1'b0, 1'b0, 1'b0, 4'd1, 16'hFFFF, e);
      base = e;
      wait_to(base + 3); check("br_rsp3", 32'(rsp_valid_o), 32'd0);
      wait_to(base + 4);
      check("br_rsp4",  32'(rsp_valid_o), 32'd1);
      check("br_data4", 32'(rsp_data_o),  32'h007E);
      rand_bus = 1;
      wait_idle();

      // five back-to-back word writes into a 4-deep FIFO
      for (int i = 0; i < 4; i++)
         push_req(1'b1, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 16'($urandom), acc[i]);
      wait_to(acc[0] + 4); check("b2b_ready_low", 32'(req_ready_o), 32'd0);
      push_req(1'b1, 1'b1, 1'b0, 4'd9, 16'($urandom), acc[4]);
      check("b2b_acc1", 32'(acc[1] - acc[0]), 32'd1);
      check("b2b_acc2", 32'(acc[2] - acc[0]), 32'd2);
      check("b2b_acc3", 32'(acc[3] - acc[0]), 32'd3);
      check("b2b_acc4", 32'(acc[4] - acc[0]), 32'd11);
      wait_to(acc[0] + 50); check("b2b_busy50", 32'(busy_o), 32'd1);
      wait_to(acc[0] + 51); check("b2b_busy51", 32'(busy_o), 32'd0);
      wait_idle();

      // reset during the strobe of a word write with two more entries queued
      push_req(1'b1, 1'b0, 1'b0, 4'd1, 16'h0011, e);
      base = e;
      push_req(1'b1, 1'b1, 1'b0, 4'd5, 16'hBEEF, e);
      push_req(1'b1, 1'b0, 1'b1, 4'd6, 16'h0022, e);
      push_req(1'b0, 1'b1, 1'b0, 4'd7, 16'h0000, e);
      wait_to(base + 7);
      check("mr_cs_before", 32'(bus_cs_n_o), 32'd0);
      #2 reset_i = 1'b0;
      model_reset();
      #1;
      check("mr_cs_async", 32'(bus_cs_n_o),  32'd1);
      check("mr_busy",     32'(busy_o),      32'd0);
      check("mr_ready",    32'(req_ready_o), 32'd1);
      tick();
      tick();
      reset_i = 1'b1;
      r = cyc;
      lows = 0;
      for (int i = 1; i <= 12; i++) begin
         wait_to(r + i);
         if (bus_cs_n_o !== 1'b1) lows++;
      end
      check("mr_no_strobes", 32'(lows), 32'd0);
      check("mr_busy_after", 32'(busy_o), 32'd0);
      rand_bus = 0;
      bus_data_i = 8'h3C;
      push_req(1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, e);
      base = e;
      wait_to(base + 4);
      check("mr_rd_valid", 32'(rsp_valid_o), 32'd1);
      check("mr_rd_data",  32'(rsp_data_o),  32'h003C);
      rand_bus = 1;
      wait_idle();

      // randomized traffic
      for (int i = 0; i < 250; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         push_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 16'($urandom), e);
      end
      wait_idle();

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xosera_bus_ctrl.md
# xosera_bus_ctrl

Sequencer that owns the Xosera 8-bit register bus on behalf of the CPU-side peripheral decoder. It accepts 8- or 16-bit register read/write requests through a valid/ready port and queues them in a small FIFO. Each request becomes one or two byte strobes with programmable chip-select pulse width and inter-access gap. Read results are returned as a single-cycle response. It replaces the single-pulse register stage between the SoC address decoder and the `vga` block's Xosera bus inputs.

## Interface
- `CS_WIDTH`, 2, cycles `bus_cs_n_o` is held low per byte access (≥1)
- `GAP`, 2, cycles `bus_cs_n_o` is held high after each strobe (≥1)
- `DEPTH`, 4, request FIFO entries (power of 2, ≥2)
- `clk`  in  1  system clock; the only clock
- `reset_i`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  FIFO can accept; equals !full
- `req_write_i`  in  1  1 = write, 0 = read
- `req_word_i`  in  1  1 = 16-bit access (even byte then odd byte), 0 = single byte
- `req_bytesel_i`  in  1  byte select for single-byte access; ignored when `req_word_i`=1
- `req_reg_num_i`  in  4  Xosera register number
- `req_data_i`  in  16  write data
- `rsp_valid_o`  out  1  one-cycle pulse: read data valid
- `rsp_data_o`  out  16  read data
- `busy_o`  out  1  FSM not IDLE or FIFO non-empty
- `bus_cs_n_o`, `bus_rd_nwr_o`  out  1 each  Xosera select (active low); 1 = read
- `bus_reg_num_o`  out  4  register number
- `bus_bytesel_o`  out  1  0 = even byte, 1 = odd byte
- `bus_data_o`  out  8  write byte
- `bus_data_i`  in  8  read byte

## Operation
- Push on `req_valid_i && req_ready_o`. There is no push-through when full, even if a pop happens in the same cycle.
- The head entry stays in the FIFO until its access completes. It is popped in the last GAP cycle of its final byte.
- FSM states:
  - IDLE: go to SETUP when the FIFO is non-empty.
  - SETUP: 1 cycle. Drive reg_num, bytesel, rd_nwr and data; `bus_cs_n_o`=1. Go to STROBE.
  - STROBE: CS_WIDTH cycles with `bus_cs_n_o`=0. Address and data are held stable. Go to GAP.
  - GAP: GAP cycles with `bus_cs_n_o`=1. Address and data are held stable. After GAP:
    - if this is a word access and the odd byte is still pending, go to SETUP for the odd byte;
    - else, if the FIFO still holds another entry after the pop, go to SETUP (no IDLE cycle);
    - else go to IDLE.
- Byte order is big-endian:
  - even byte (bytesel 0) carries `req_data_i[15:8]` / `rsp_data_o[15:8]`;
  - odd byte carries `[7:0]`.
- Single-byte access uses `req_bytesel_i`. Write data comes from `req_data_i[7:0]`. Read returns `{8'h00, byte}`.
- Read capture: sample `bus_data_i` on the clock edge ending the last STROBE cycle of each byte.
- `rsp_valid_o` pulses for one cycle in the first GAP cycle after the final strobe of a read. There is no backpressure. `rsp_data_o` holds its value until the next read response.
- Writes produce no response.
- Reset values:
  - `bus_cs_n_o`=1, `bus_rd_nwr_o`=1; all other bus outputs 0;
  - `rsp_valid_o`=0, `rsp_data_o`=0, `busy_o`=0;
  - `req_ready_o`=1; FIFO empty; FSM in IDLE.
- Reset mid-access: `bus_cs_n_o` rises immediately (asynchronously). Queued requests are discarded and no response is emitted.

## Timing
- Cycle numbering: request accepted at edge 0; cycle 1 follows that edge.
- Byte access:
  - SETUP in cycle 1;
  - STROBE in cycles 2 to 1+CS_WIDTH;
  - GAP in cycles 2+CS_WIDTH to 1+CS_WIDTH+GAP.
- Byte access total: 1+CS_WIDTH+GAP cycles. Word access: twice that, with no gap between the two byte sequences beyond GAP.
- With defaults (CS_WIDTH=2, GAP=2):
  - byte access: `busy_o` low from cycle 6;
  - word access: `busy_o` low from cycle 11; word-read `rsp_valid_o` in cycle 9.
- `req_ready_o` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop.
- Bus outputs are registered; they never glitch while `bus_cs_n_o`=0.

## Test plan
- Byte write (reg 3, bytesel 1, data 0x005A), defaults → SETUP in cycle 1; `bus_cs_n_o`=0 in cycles 2–3 with `bus_data_o`=0x5A, `bus_rd_nwr_o`=0, `bus_bytesel_o`=1, `bus_reg_num_o`=3; no `rsp_valid_o`; `busy_o`=0 in cycle 6.
- Word write (reg 5, 0x1234) → strobe in cycles 2–3 with bytesel 0, data 0x12; strobe in cycles 7–8 with bytesel 1, data 0x34; `busy_o`=0 in cycle 11.
- Word read (reg 2); bench drives `bus_data_i`=0xAB during the first strobe and 0xCD during the second → `rsp_valid_o` high only in cycle 9 with `rsp_data_o`=0xABCD.
- Five back-to-back word writes, DEPTH=4 → first four accepted on consecutive cycles; `req_ready_o` low until the first entry is popped in cycle 10; fifth accepted afterwards. All five executed in order, with no IDLE cycle between accesses.
- Byte read, bytesel 0, `bus_data_i`=0x7E → `rsp_data_o`=0x007E in cycle 4.
- `reset_i` asserted low during cycle 2 of a word write with two more entries queued → `bus_cs_n_o`=1 immediately; `busy_o`=0, `req_ready_o`=1, no strobes after release. A new byte read after release completes normally.
